// File: rtl/serial_tx_arbiter_if.sv
// Requester/serializer handshake bundle for serial_tx_arbiter.
// master: the requester side (packet sources plus serializer sink).
// slave:  the arbiter itself.
interface serial_tx_arbiter_if;
    logic [1:0] req;
    logic [1:0] valid;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] last;
    logic [1:0] ack;
    logic [1:0] grant;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       pkt_abort;

    modport master (
        output req, valid, data0, data1, last,
        input  ack, grant, data_out, data_out_valid, pkt_abort
    );

    modport slave (
        input  req, valid, data0, data1, last,
        output ack, grant, data_out, data_out_valid, pkt_abort
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: hands one byte serializer to one of two requesters for a
// whole packet and paces bytes at BITS_PER_BYTE cycles each.
// Build option: define SERIAL_TX_ARB_FIXED_PRIO_EN to make requester 0 win every
// tie (no round-robin pointer). Default build is round-robin.
module serial_tx_arbiter #(
    parameter int BITS_PER_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_tx_arbiter_if.slave bus
);

    localparam int CNT_W = (BITS_PER_BYTE > 2) ? $clog2(BITS_PER_BYTE - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BITS_PER_BYTE - 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             owner_reg, owner_next;
    logic             last_reg, last_next;
    logic [1:0]       grant_reg, grant_next;
    logic [1:0]       ack_reg, ack_next;
    logic [7:0]       data_out_reg, data_out_next;
    logic             dov_reg, dov_next;
    logic             abort_reg, abort_next;

    logic       ptr_cur;
    logic       pick;
    logic [1:0] pick_onehot;
    logic [1:0] owner_onehot;
    logic       owner_req;
    logic       owner_valid;
    logic       owner_last;
    logic [7:0] owner_data;

    // Only the current owner's inputs matter; the other requester is invisible.
    assign owner_req   = bus.req[owner_reg];
    assign owner_valid = bus.valid[owner_reg];
    assign owner_last  = bus.last[owner_reg];
    assign owner_data  = owner_reg ? bus.data1 : bus.data0;

    // Requester 1 wins when it is alone, or on a tie when the pointer names it.
    assign pick = bus.req[1] & (~bus.req[0] | ptr_cur);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
            assign pick_onehot[gi]  = (pick == 1'(gi));
            assign owner_onehot[gi] = (owner_reg == 1'(gi));
        end
    endgenerate

`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
    assign ptr_cur = 1'b0;
`else
    logic ptr_reg;
    logic pkt_end;

    // A packet ends either on abort in GRANT or after the last byte has shifted out.
    assign pkt_end = ((state_reg == ST_GRANT) && !owner_req) ||
                     ((state_reg == ST_SEND) && (cnt_reg == '0) && last_reg);
    assign ptr_cur = ptr_reg;

    // Hand tie priority to the other requester whenever the owner's packet ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (pkt_end) begin
            ptr_reg <= ~owner_reg;
        end
    end
`endif

    // Packet FSM: arbitrate in IDLE, take one byte per GRANT, wait out the shift in SEND.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        grant_next    = grant_reg;
        data_out_next = data_out_reg;
        ack_next      = 2'b00;
        dov_next      = 1'b0;
        abort_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                grant_next = 2'b00;
                if (|bus.req) begin
                    owner_next = pick;
                    grant_next = pick_onehot;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    // Owner gave up mid-packet: release and flag it.
                    abort_next = 1'b1;
                    grant_next = 2'b00;
                    state_next = ST_IDLE;
                end else if (owner_valid) begin
                    data_out_next = owner_data;
                    dov_next      = 1'b1;
                    ack_next      = owner_onehot;
                    last_next     = owner_last;
                    cnt_next      = CNT_LOAD;
                    state_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_reg == '0) begin
                    if (last_reg) begin
                        grant_next = 2'b00;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_GRANT;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                grant_next = 2'b00;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            owner_reg    <= 1'b0;
            last_reg     <= 1'b0;
            grant_reg    <= 2'b00;
            ack_reg      <= 2'b00;
            data_out_reg <= 8'h00;
            dov_reg      <= 1'b0;
            abort_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            grant_reg    <= grant_next;
            ack_reg      <= ack_next;
            data_out_reg <= data_out_next;
            dov_reg      <= dov_next;
            abort_reg    <= abort_next;
        end
    end

    assign bus.ack            = ack_reg;
    assign bus.grant          = grant_reg;
    assign bus.data_out       = data_out_reg;
    assign bus.data_out_valid = dov_reg;
    assign bus.pkt_abort      = abort_reg;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: an 8-cycle-per-byte instance and a
// 2-cycle-per-byte instance sharing clock and reset.
module tb_serial_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_tx_arbiter_if bus ();
    serial_tx_arbiter_if bus2 ();

    serial_tx_arbiter #(.BITS_PER_BYTE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_tx_arbiter #(.BITS_PER_BYTE(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one cycle; outputs are then stable and inputs may be changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req = 2'b00;  bus.valid = 2'b00;  bus.last = 2'b00;
        bus.data0 = 8'h00; bus.data1 = 8'h00;
        bus2.req = 2'b00; bus2.valid = 2'b00; bus2.last = 2'b00;
        bus2.data0 = 8'h00; bus2.data1 = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_pulse(input int which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((which == 0) ? bus.data_out_valid : bus2.data_out_valid) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    // Both requesters post a one-byte packet; each drops req after its ack.
    task automatic run_contention(output logic [7:0] d0, output logic [7:0] d1,
                                  output logic [1:0] a0, output logic [1:0] a1,
                                  output int n);
        bus.req = 2'b11; bus.valid = 2'b11; bus.last = 2'b11;
        bus.data0 = 8'h11; bus.data1 = 8'h22;
        n = 0; d0 = 8'h00; d1 = 8'h00; a0 = 2'b00; a1 = 2'b00;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.data_out_valid) begin
                if (n == 0) begin d0 = bus.data_out; a0 = bus.ack; end
                if (n == 1) begin d1 = bus.data_out; a1 = bus.ack; end
                if (bus.ack[0]) begin bus.req[0] = 1'b0; bus.valid[0] = 1'b0; end
                if (bus.ack[1]) begin bus.req[1] = 1'b0; bus.valid[1] = 1'b0; end
                n++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit         seen;
        int         cnt_a, cnt_b;
        logic [7:0] d0, d1;
        logic [1:0] a0, a1;
        int         n;
        logic [1:0] acks [4];
        logic [1:0] exp_ack;

        // ---- reset state
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check_val("rst_grant", bus.grant, 2'b00);
        check_val("rst_ack", bus.ack, 2'b00);
        check_val("rst_data_out", bus.data_out, 8'h00);
        check_val("rst_dov", bus.data_out_valid, 1'b0);
        check_val("rst_abort", bus.pkt_abort, 1'b0);
        rst = 1'b0;

        // ---- single packet A5, 3C
        bus.req = 2'b01; bus.valid = 2'b01; bus.data0 = 8'hA5; bus.last = 2'b00;
        step();
        check_val("t1_grant", bus.grant, 2'b01);
        check_val("t1_no_early_dov", bus.data_out_valid, 1'b0);
        step();
        check_val("t1_dov1", bus.data_out_valid, 1'b1);
        check_val("t1_data1", bus.data_out, 8'hA5);
        check_val("t1_ack1", bus.ack, 2'b01);
        bus.data0 = 8'h3C; bus.last = 2'b01;
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.data_out_valid) cnt_a++;
        end
        check_val("t1_spacing_quiet", cnt_a, 0);
        step();
        check_val("t1_dov2", bus.data_out_valid, 1'b1);
        check_val("t1_data2", bus.data_out, 8'h3C);
        check_val("t1_ack2", bus.ack, 2'b01);
        bus.req = 2'b00; bus.valid = 2'b00; bus.last = 2'b00;
        for (int i = 0; i < 6; i++) step();
        check_val("t1_grant_held_6", bus.grant, 2'b01);
        step();
        check_val("t1_grant_free_7", bus.grant, 2'b00);

        // ---- round-robin contention from reset, twice
        do_reset();
        run_contention(d0, d1, a0, a1, n);
        check_val("rr1_count", n, 2);
        check_val("rr1_first", d0, 8'h11);
        check_val("rr1_first_ack", a0, 2'b01);
        check_val("rr1_second", d1, 8'h22);
        check_val("rr1_second_ack", a1, 2'b10);
        run_contention(d0, d1, a0, a1, n);
        check_val("rr2_count", n, 2);
        check_val("rr2_first", d0, 8'h11);
        check_val("rr2_second", d1, 8'h22);

        // ---- both requesters asking continuously
        do_reset();
        bus.req = 2'b11; bus.valid = 2'b11; bus.last = 2'b11;
        bus.data0 = 8'h11; bus.data1 = 8'h22;
        n = 0; cnt_b = 0;
        for (int i = 0; i < 4; i++) acks[i] = 2'b00;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.grant[1]) cnt_b++;
            if (bus.data_out_valid) begin
                if (n < 4) acks[n] = bus.ack;
                n++;
            end
        end
        for (int i = 0; i < 4; i++) begin
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
            exp_ack = 2'b01;
`else
            exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            check_val($sformatf("cont_ack%0d", i), acks[i], exp_ack);
        end
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
        check_val("fp_r1_never_granted", cnt_b, 0);
`endif

        // ---- inter-byte gap
        do_reset();
        bus.req = 2'b01; bus.valid = 2'b01; bus.data0 = 8'h5A; bus.last = 2'b00;
        wait_pulse(0, 10, seen);
        check_val("gap_first_seen", seen, 1'b1);
        check_val("gap_first_data", bus.data_out, 8'h5A);
        bus.valid = 2'b00; bus.data0 = 8'hC3; bus.last = 2'b01;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.data_out_valid) cnt_a++;
            if (bus.grant != 2'b01) cnt_b++;
        end
        check_val("gap_no_dov", cnt_a, 0);
        check_val("gap_grant_drops", cnt_b, 0);
        bus.valid = 2'b01;
        step();
        check_val("gap_resume_dov", bus.data_out_valid, 1'b1);
        check_val("gap_resume_data", bus.data_out, 8'hC3);
        idle_inputs();

        // ---- abort with a pending second requester
        do_reset();
        bus.req = 2'b11; bus.valid = 2'b11; bus.last = 2'b10;
        bus.data0 = 8'h01; bus.data1 = 8'h77;
        wait_pulse(0, 10, seen);
        check_val("ab_first_seen", seen, 1'b1);
        check_val("ab_first_ack", bus.ack, 2'b01);
        bus.data0 = 8'h02; bus.req[0] = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (bus.pkt_abort) cnt_a++;
            if (bus.data_out_valid) cnt_b++;
        end
        check_val("ab_no_early_abort", cnt_a, 0);
        check_val("ab_no_dov", cnt_b, 0);
        step();
        check_val("ab_abort_pulse", bus.pkt_abort, 1'b1);
        check_val("ab_grant_zero", bus.grant, 2'b00);
        step();
        check_val("ab_abort_single", bus.pkt_abort, 1'b0);
        check_val("ab_other_granted", bus.grant, 2'b10);
        step();
        check_val("ab_other_dov", bus.data_out_valid, 1'b1);
        check_val("ab_other_data", bus.data_out, 8'h77);
        check_val("ab_other_ack", bus.ack, 2'b10);
        idle_inputs();

        // ---- reset during SEND
        do_reset();
        bus.req = 2'b01; bus.valid = 2'b01; bus.data0 = 8'h99; bus.last = 2'b00;
        wait_pulse(0, 10, seen);
        check_val("mr_first_seen", seen, 1'b1);
        step(); step(); step();
        rst = 1'b1;
        step();
        check_val("mr_grant", bus.grant, 2'b00);
        check_val("mr_dov", bus.data_out_valid, 1'b0);
        check_val("mr_data_out", bus.data_out, 8'h00);
        check_val("mr_ack", bus.ack, 2'b00);
        check_val("mr_abort", bus.pkt_abort, 1'b0);
        rst = 1'b0;
        idle_inputs();
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.data_out_valid || bus.pkt_abort || (bus.grant != 2'b00)) cnt_a++;
        end
        check_val("mr_quiet_after", cnt_a, 0);

        // ---- BITS_PER_BYTE = 2 instance
        do_reset();
        bus2.req = 2'b01; bus2.valid = 2'b01; bus2.data0 = 8'h10; bus2.last = 2'b00;
        wait_pulse(1, 10, seen);
        check_val("b2_first_seen", seen, 1'b1);
        check_val("b2_data1", bus2.data_out, 8'h10);
        bus2.data0 = 8'h20;
        step();
        check_val("b2_gap1", bus2.data_out_valid, 1'b0);
        step();
        check_val("b2_dov2", bus2.data_out_valid, 1'b1);
        check_val("b2_data2", bus2.data_out, 8'h20);
        bus2.data0 = 8'h30; bus2.last = 2'b01;
        step();
        check_val("b2_gap2", bus2.data_out_valid, 1'b0);
        step();
        check_val("b2_dov3", bus2.data_out_valid, 1'b1);
        check_val("b2_data3", bus2.data_out, 8'h30);
        idle_inputs();
        step();
        check_val("b2_grant_free", bus2.grant, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
